// File: rtl/axi_err_pkg.sv
// Shared types and constants for the AXI error responder.
package axi_err_pkg;

  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_bus.sv
// Minimal AXI4 bus interface carrying the channels the error responder touches.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1
);

  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

  modport Master (
    output aw_id, aw_addr, aw_len, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

endinterface

// File: rtl/axi_err_slave_rd.sv
// Read beat generator: accepts one AR at a time and returns ar_len+1 DECERR beats.
module axi_err_slave_rd
  import axi_err_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_valid,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [7:0]        ar_len,
  input  logic [USER_W-1:0] ar_user,
  output logic              ar_ready,
  input  logic              r_ready,
  output logic              r_valid,
  output logic              r_last,
  output logic [ID_W-1:0]   r_id,
  output logic [USER_W-1:0] r_user
);

  rd_state_e  state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] len;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= R_IDLE;
    else     state <= state_nxt;
  end

  // The counter may wrap past len on the final beat; the next AR clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      len    <= '0;
      r_id   <= '0;
      r_user <= '0;
    end else if (ar_valid && ar_ready) begin
      cnt    <= '0;
      len    <= ar_len;
      r_id   <= ar_id;
      r_user <= ar_user;
    end else if (r_valid && r_ready) begin
      cnt    <= cnt + 8'd1;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_last    = 1'b0;
    case (state)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (ar_valid) state_nxt = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        r_last  = (cnt == len);
        if (r_ready && r_last) state_nxt = R_IDLE;
      end
      default: state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: rtl/axi_err_slave.sv
// AXI4 responder for unmapped addresses: every request is answered with DECERR.
// Define AXI_ERR_SLAVE_CAPTURE_EN to record the address of the latest errored request.
module axi_err_slave
  import axi_err_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  AXI_BUS.Slave                     slave,
  output logic [AXI_ADDR_WIDTH-1:0] err_addr_o,
  output logic                      err_valid_o,
  input  logic                      err_clr_i
);

  wr_state_e                 w_state, w_state_nxt;
  logic                      aw_ready, w_ready, b_valid;
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      aw_hs, ar_hs;

  assign aw_hs = slave.aw_valid && aw_ready;
  assign ar_hs = slave.ar_valid && slave.ar_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_id   <= '0;
      b_user <= '0;
    end else if (aw_hs) begin
      b_id   <= slave.aw_id;
      b_user <= slave.aw_user;
    end
  end

  // Write data is swallowed; only w_last matters, so aw_len is never consulted.
  always_comb begin
    w_state_nxt = w_state;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (slave.aw_valid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (slave.w_valid && slave.w_last) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (slave.b_ready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign slave.aw_ready = aw_ready;
  assign slave.w_ready  = w_ready;
  assign slave.b_valid  = b_valid;
  assign slave.b_id     = b_id;
  assign slave.b_user   = b_user;
  assign slave.b_resp   = AXI_RESP_DECERR;
  assign slave.r_resp   = AXI_RESP_DECERR;
  assign slave.r_data   = '0;

  axi_err_slave_rd #(
    .ID_W   (AXI_ID_WIDTH),
    .USER_W (AXI_USER_WIDTH)
  ) u_rd (
    .clk      (clk),
    .rst      (rst),
    .ar_valid (slave.ar_valid),
    .ar_id    (slave.ar_id),
    .ar_len   (slave.ar_len),
    .ar_user  (slave.ar_user),
    .ar_ready (slave.ar_ready),
    .r_ready  (slave.r_ready),
    .r_valid  (slave.r_valid),
    .r_last   (slave.r_last),
    .r_id     (slave.r_id),
    .r_user   (slave.r_user)
  );

  logic unused_ok;
  assign unused_ok = ^{slave.aw_len, slave.w_data, slave.w_strb, slave.w_user};

`ifdef AXI_ERR_SLAVE_CAPTURE_EN
  logic [AXI_ADDR_WIDTH-1:0] err_addr_q;
  logic                      err_valid_q;

  // A fresh capture outranks a clear, and AW outranks AR in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else if (aw_hs) begin
      err_addr_q  <= slave.aw_addr;
      err_valid_q <= 1'b1;
    end else if (ar_hs) begin
      err_addr_q  <= slave.ar_addr;
      err_valid_q <= 1'b1;
    end else if (err_clr_i) begin
      err_valid_q <= 1'b0;
    end
  end

  assign err_addr_o  = err_addr_q;
  assign err_valid_o = err_valid_q;
`else
  logic unused_capture;
  assign unused_capture = ^{slave.aw_addr, slave.ar_addr, err_clr_i, aw_hs, ar_hs};
  assign err_addr_o  = '0;
  assign err_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_err_slave.sv
// Directed bench for axi_err_slave; expectations follow AXI_ERR_SLAVE_CAPTURE_EN when defined.
module tb_axi_err_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int UW = 1;
`ifdef AXI_ERR_SLAVE_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          err_clr;
  logic [AW-1:0] err_addr;
  logic          err_valid;
  int            n_cmp = 0;
  int            n_bad = 0;

  AXI_BUS #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .AXI_ID_WIDTH   (IW),
    .AXI_USER_WIDTH (UW)
  ) bus ();

  axi_err_slave #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .AXI_ID_WIDTH   (IW),
    .AXI_USER_WIDTH (UW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slave       (bus),
    .err_addr_o  (err_addr),
    .err_valid_o (err_valid),
    .err_clr_i   (err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
    return CAP ? a : '0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.aw_ready !== 1'b1) begin n_bad++; $display("FAIL rst_aw_ready: got %b want 1", bus.aw_ready); end
    n_cmp++; if (bus.ar_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ar_ready: got %b want 1", bus.ar_ready); end
    n_cmp++; if (bus.w_ready !== 1'b0) begin n_bad++; $display("FAIL rst_w_ready: got %b want 0", bus.w_ready); end
    n_cmp++; if (bus.b_valid !== 1'b0) begin n_bad++; $display("FAIL rst_b_valid: got %b want 0", bus.b_valid); end
    n_cmp++; if (bus.r_valid !== 1'b0) begin n_bad++; $display("FAIL rst_r_valid: got %b want 0", bus.r_valid); end
    n_cmp++; if (bus.r_last !== 1'b0) begin n_bad++; $display("FAIL rst_r_last: got %b want 0", bus.r_last); end
    n_cmp++; if (bus.b_resp !== 2'b11) begin n_bad++; $display("FAIL rst_b_resp: got %b want 11", bus.b_resp); end
    n_cmp++; if (bus.r_resp !== 2'b11) begin n_bad++; $display("FAIL rst_r_resp: got %b want 11", bus.r_resp); end
    n_cmp++; if (bus.b_id !== 4'h0 || bus.b_user !== 1'b0) begin n_bad++; $display("FAIL rst_b_id_user: got %h/%b want 0/0", bus.b_id, bus.b_user); end
    n_cmp++; if (bus.r_id !== 4'h0 || bus.r_user !== 1'b0) begin n_bad++; $display("FAIL rst_r_id_user: got %h/%b want 0/0", bus.r_id, bus.r_user); end
    n_cmp++; if (bus.r_data !== 32'h0) begin n_bad++; $display("FAIL rst_r_data: got %h want 0", bus.r_data); end
    n_cmp++; if (err_addr !== 32'h0 || err_valid !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %h/%b want 0/0", err_addr, err_valid); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.aw_id = 4'd5; bus.aw_addr = 32'h3000_0000; bus.aw_user = 1'b1; bus.aw_len = 8'd0;
    @(negedge clk);
    bus.aw_valid = 1'b0;
    n_cmp++; if (bus.aw_ready !== 1'b0) begin n_bad++; $display("FAIL wr_aw_busy: got %b want 0", bus.aw_ready); end
    n_cmp++; if (bus.w_ready !== 1'b1) begin n_bad++; $display("FAIL wr_w_ready: got %b want 1", bus.w_ready); end
    n_cmp++; if (bus.b_valid !== 1'b0) begin n_bad++; $display("FAIL wr_b_early: got %b want 0", bus.b_valid); end
    bus.w_valid = 1'b1; bus.w_last = 1'b1; bus.w_data = 32'hDEAD_BEEF; bus.w_strb = 4'hF;
    @(negedge clk);
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    n_cmp++; if (bus.b_valid !== 1'b1) begin n_bad++; $display("FAIL wr_b_valid: got %b want 1", bus.b_valid); end
    n_cmp++; if (bus.b_id !== 4'd5 || bus.b_user !== 1'b1) begin n_bad++; $display("FAIL wr_b_id_user: got %h/%b want 5/1", bus.b_id, bus.b_user); end
    n_cmp++; if (bus.b_resp !== 2'b11) begin n_bad++; $display("FAIL wr_b_resp: got %b want 11", bus.b_resp); end
    n_cmp++; if (bus.w_ready !== 1'b0) begin n_bad++; $display("FAIL wr_w_done: got %b want 0", bus.w_ready); end
    n_cmp++; if (err_addr !== exp_addr(32'h3000_0000) || err_valid !== CAP) begin n_bad++; $display("FAIL wr_err_capture: got %h/%b want %h/%b", err_addr, err_valid, exp_addr(32'h3000_0000), CAP); end
    @(negedge clk);
    n_cmp++; if (bus.b_valid !== 1'b1 || bus.b_id !== 4'd5) begin n_bad++; $display("FAIL wr_b_hold: got %b/%h want 1/5", bus.b_valid, bus.b_id); end
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    n_cmp++; if (bus.b_valid !== 1'b0) begin n_bad++; $display("FAIL wr_b_drop: got %b want 0", bus.b_valid); end
    n_cmp++; if (bus.aw_ready !== 1'b1) begin n_bad++; $display("FAIL wr_aw_again: got %b want 1", bus.aw_ready); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++; if (err_valid !== 1'b0 || err_addr !== exp_addr(32'h3000_0000)) begin n_bad++; $display("FAIL wr_err_clr: got %h/%b want %h/0", err_addr, err_valid, exp_addr(32'h3000_0000)); end
  endtask

  task automatic test_multi_beat_write();
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.aw_id = 4'hC; bus.aw_addr = 32'h0000_0055; bus.aw_user = 1'b0; bus.aw_len = 8'd1;
    @(negedge clk);
    bus.aw_valid = 1'b0;
    bus.w_valid = 1'b1; bus.w_last = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.w_ready !== 1'b1 || bus.b_valid !== 1'b0) begin n_bad++; $display("FAIL mw_mid_beat: got w_ready %b b_valid %b want 1/0", bus.w_ready, bus.b_valid); end
    bus.w_last = 1'b1; bus.b_ready = 1'b1;
    @(negedge clk);
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    n_cmp++; if (bus.b_valid !== 1'b1 || bus.b_id !== 4'hC || bus.b_user !== 1'b0) begin n_bad++; $display("FAIL mw_b: got %b/%h/%b want 1/c/0", bus.b_valid, bus.b_id, bus.b_user); end
    @(negedge clk);
    bus.b_ready = 1'b0;
    n_cmp++; if (bus.b_valid !== 1'b0 || bus.aw_ready !== 1'b1) begin n_bad++; $display("FAIL mw_idle: got b_valid %b aw_ready %b want 0/1", bus.b_valid, bus.aw_ready); end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [7:0] len, input logic [AW-1:0] addr,
                         input bit toggle, input string tag);
    int         beats = 0;
    int         cyc = 0;
    bit         done = 1'b0;
    bit         prev_stall = 1'b0;
    bit         rr;
    logic [3:0] p_id;
    logic       p_last;
    logic [DW-1:0] p_data;
    logic [1:0] p_resp;
    @(negedge clk);
    bus.ar_valid = 1'b1; bus.ar_id = id; bus.ar_len = len; bus.ar_addr = addr; bus.ar_user = 1'b1; bus.r_ready = 1'b0;
    @(negedge clk);
    bus.ar_valid = 1'b0;
    n_cmp++; if (bus.ar_ready !== 1'b0) begin n_bad++; $display("FAIL %s_ar_busy: got %b want 0", tag, bus.ar_ready); end
    n_cmp++; if (err_addr !== exp_addr(addr)) begin n_bad++; $display("FAIL %s_err_addr: got %h want %h", tag, err_addr, exp_addr(addr)); end
    rr = toggle ? 1'b0 : 1'b1;
    while (!done && cyc < 4 * (int'(len) + 1) + 8) begin
      n_cmp++; if (bus.r_valid !== 1'b1) begin n_bad++; $display("FAIL %s_r_valid: got %b want 1 at beat %0d", tag, bus.r_valid, beats); end
      if (prev_stall) begin
        n_cmp++;
        if (bus.r_id !== p_id || bus.r_last !== p_last || bus.r_data !== p_data || bus.r_resp !== p_resp) begin
          n_bad++; $display("FAIL %s_stall_hold: got %h/%b/%h/%b want %h/%b/%h/%b", tag, bus.r_id, bus.r_last, bus.r_data, bus.r_resp, p_id, p_last, p_data, p_resp);
        end
      end
      n_cmp++; if (bus.r_data !== 32'h0 || bus.r_resp !== 2'b11) begin n_bad++; $display("FAIL %s_r_payload: got %h/%b want 0/11", tag, bus.r_data, bus.r_resp); end
      n_cmp++; if (bus.r_id !== id || bus.r_user !== 1'b1) begin n_bad++; $display("FAIL %s_r_id: got %h/%b want %h/1", tag, bus.r_id, bus.r_user, id); end
      n_cmp++; if (bus.r_last !== (beats == int'(len))) begin n_bad++; $display("FAIL %s_r_last: got %b want %b at beat %0d", tag, bus.r_last, (beats == int'(len)), beats); end
      bus.r_ready = rr;
      prev_stall = bus.r_valid && !rr;
      p_id = bus.r_id; p_last = bus.r_last; p_data = bus.r_data; p_resp = bus.r_resp;
      if (bus.r_valid && rr) begin
        if (bus.r_last) done = 1'b1;
        beats++;
      end
      if (toggle) rr = ~rr;
      cyc++;
      @(negedge clk);
    end
    bus.r_ready = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s_timeout: got done %b want 1 after %0d cycles", tag, done, cyc); end
    n_cmp++; if (beats != int'(len) + 1) begin n_bad++; $display("FAIL %s_beats: got %0d want %0d", tag, beats, int'(len) + 1); end
    n_cmp++; if (bus.ar_ready !== 1'b1 || bus.r_valid !== 1'b0) begin n_bad++; $display("FAIL %s_idle: got ar_ready %b r_valid %b want 1/0", tag, bus.ar_ready, bus.r_valid); end
  endtask

  task automatic test_read_burst();
    do_read(4'd9, 8'd3, 32'h0000_0040, 1'b0, "rd_burst");
  endtask

  task automatic test_backpressure();
    do_read(4'd6, 8'd1, 32'h0000_0080, 1'b1, "rd_bp");
  endtask

  task automatic test_max_len();
    do_read(4'hA, 8'd255, 32'h0000_0100, 1'b0, "rd_max");
  endtask

  task automatic test_concurrency();
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.aw_id = 4'd2; bus.aw_addr = 32'h1; bus.aw_user = 1'b0;
    bus.ar_valid = 1'b1; bus.ar_id = 4'd3; bus.ar_addr = 32'h2; bus.ar_len = 8'd0; bus.ar_user = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    bus.aw_valid = 1'b0; bus.ar_valid = 1'b0; err_clr = 1'b0;
    n_cmp++; if (err_addr !== exp_addr(32'h1) || err_valid !== CAP) begin n_bad++; $display("FAIL cc_err_priority: got %h/%b want %h/%b", err_addr, err_valid, exp_addr(32'h1), CAP); end
    n_cmp++; if (bus.aw_ready !== 1'b0 || bus.ar_ready !== 1'b0) begin n_bad++; $display("FAIL cc_both_busy: got %b/%b want 0/0", bus.aw_ready, bus.ar_ready); end
    n_cmp++; if (bus.r_valid !== 1'b1 || bus.r_id !== 4'd3 || bus.r_last !== 1'b1) begin n_bad++; $display("FAIL cc_r_beat: got %b/%h/%b want 1/3/1", bus.r_valid, bus.r_id, bus.r_last); end
    n_cmp++; if (bus.w_ready !== 1'b1) begin n_bad++; $display("FAIL cc_w_ready: got %b want 1", bus.w_ready); end
    bus.w_valid = 1'b1; bus.w_last = 1'b1; bus.r_ready = 1'b1;
    @(negedge clk);
    bus.w_valid = 1'b0; bus.w_last = 1'b0; bus.r_ready = 1'b0;
    n_cmp++; if (bus.b_valid !== 1'b1 || bus.b_id !== 4'd2) begin n_bad++; $display("FAIL cc_b: got %b/%h want 1/2", bus.b_valid, bus.b_id); end
    n_cmp++; if (bus.r_valid !== 1'b0 || bus.ar_ready !== 1'b1) begin n_bad++; $display("FAIL cc_rd_idle: got r_valid %b ar_ready %b want 0/1", bus.r_valid, bus.ar_ready); end
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    n_cmp++; if (bus.b_valid !== 1'b0 || bus.aw_ready !== 1'b1) begin n_bad++; $display("FAIL cc_wr_idle: got b_valid %b aw_ready %b want 0/1", bus.b_valid, bus.aw_ready); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.ar_valid = 1'b1; bus.ar_id = 4'd7; bus.ar_addr = 32'h0000_0200; bus.ar_len = 8'd7; bus.ar_user = 1'b0;
    @(negedge clk);
    bus.ar_valid = 1'b0; bus.r_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if (bus.r_valid !== 1'b1 || bus.r_last !== 1'b0) begin n_bad++; $display("FAIL mr_in_burst: got %b/%b want 1/0", bus.r_valid, bus.r_last); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.r_valid !== 1'b0) begin n_bad++; $display("FAIL mr_r_valid_drop: got %b want 0", bus.r_valid); end
    n_cmp++; if (bus.ar_ready !== 1'b1 || bus.r_id !== 4'd0) begin n_bad++; $display("FAIL mr_rd_reset: got ar_ready %b r_id %h want 1/0", bus.ar_ready, bus.r_id); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.r_valid !== 1'b0 || bus.ar_ready !== 1'b1) begin n_bad++; $display("FAIL mr_no_stale: got r_valid %b ar_ready %b want 0/1 cycle %0d", bus.r_valid, bus.ar_ready, i); end
    end
    bus.r_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_user = '0;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_user = '0;
    bus.b_ready = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_user = '0;
    bus.r_ready = 1'b0;
    test_reset();
    test_single_write();
    test_multi_beat_write();
    test_read_burst();
    test_backpressure();
    test_concurrency();
    test_mid_reset();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
